// File: rtl/rv32v_vmem_sequencer_if.sv
// Element-width type and the issue/coalescer-facing bundle of the vector memory sequencer.
// master drives requests and coalescer status; slave is the sequencer.
package rv32v_vmem_pkg;
   typedef enum logic [1:0] {
      SEW8  = 2'd0,
      SEW16 = 2'd1,
      SEW32 = 2'd2,
      SEW64 = 2'd3
   } vsew_t;
endpackage

interface rv32v_vmem_sequencer_if;
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_store;
   logic [1:0]                 req_mode;
   logic [31:0]                req_base;
   logic [31:0]                req_stride;
   rv32v_vmem_pkg::vsew_t      req_eew;
   logic [5:0]                 req_nuops;
   logic [2:0]                 req_nf;
   logic                       flush;
   logic                       last_lane;
   logic                       lsc_ready;
   logic                       vmemdren;
   logic                       vmemdwen;
   logic [4:0]                 vuop_num;
   logic                       vuop_last;
   logic                       vnew_seg;
   logic                       vseg_op;
   logic                       strided;
   logic                       unit_strided;
   logic                       vindexed;
   logic [31:0]                base;
   logic [31:0]                stride;
   rv32v_vmem_pkg::vsew_t      veew;
   logic                       busy;
   logic                       done;

   modport master (
      output req_valid, req_store, req_mode, req_base, req_stride, req_eew,
             req_nuops, req_nf, flush, last_lane, lsc_ready,
      input  req_ready, vmemdren, vmemdwen, vuop_num, vuop_last, vnew_seg,
             vseg_op, strided, unit_strided, vindexed, base, stride, veew,
             busy, done
   );

   modport slave (
      input  req_valid, req_store, req_mode, req_base, req_stride, req_eew,
             req_nuops, req_nf, flush, last_lane, lsc_ready,
      output req_ready, vmemdren, vmemdwen, vuop_num, vuop_last, vnew_seg,
             vseg_op, strided, unit_strided, vindexed, base, stride, veew,
             busy, done
   );
endinterface

// File: rtl/rv32v_vmem_sequencer.sv
// Steps one vector load/store through its segment fields (outer) and micro-ops (inner),
// presenting field base and effective stride to the memory coalescer.
module rv32v_vmem_sequencer
   import rv32v_vmem_pkg::*;
#(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned MAX_UOPS  = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   rv32v_vmem_sequencer_if.slave   bus
);

   localparam int unsigned UOP_W = $clog2(MAX_UOPS);
   localparam int unsigned CNT_W = UOP_W + 1;
   localparam int unsigned NF_W  = 3;

   if ((NUM_LANES == 0) || (UOP_W != 5)) begin : g_param_chk
      $error("rv32v_vmem_sequencer: unsupported NUM_LANES/MAX_UOPS");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state, w_state;
   logic                r_store, w_store;
   logic [1:0]          r_mode, w_mode;
   logic [31:0]         r_base, w_base;
   logic [31:0]         r_stride, w_stride;
   vsew_t               r_eew, w_eew;
   logic [CNT_W-1:0]    r_nuops, w_nuops;
   logic [NF_W-1:0]     r_nf, w_nf;
   logic [NF_W-1:0]     r_f, w_f;
   logic [UOP_W-1:0]    r_vuop, w_vuop;
   logic                r_new_seg, w_new_seg;

   logic                w_cmpl;
   logic                w_stall;
   logic                w_uop_last;
   logic                w_run;
   logic                w_unit;
   logic                w_strd_mode;
   logic                w_idx_mode;
   logic [31:0]         w_unit_stride;

   assign w_cmpl     = bus.last_lane && bus.lsc_ready;
   assign w_stall    = bus.last_lane && !bus.lsc_ready;
   assign w_uop_last = ({1'b0, r_vuop} == (r_nuops - CNT_W'(1)));

   // State register; flush shares the synchronous reset path and wins over completion.
   always_ff @(posedge CLK) begin
      if (RST || bus.flush) begin
         r_state   <= S_IDLE;
         r_store   <= 1'b0;
         r_mode    <= 2'd0;
         r_base    <= 32'd0;
         r_stride  <= 32'd0;
         r_eew     <= SEW8;
         r_nuops   <= '0;
         r_nf      <= '0;
         r_f       <= '0;
         r_vuop    <= '0;
         r_new_seg <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_store   <= w_store;
         r_mode    <= w_mode;
         r_base    <= w_base;
         r_stride  <= w_stride;
         r_eew     <= w_eew;
         r_nuops   <= w_nuops;
         r_nf      <= w_nf;
         r_f       <= w_f;
         r_vuop    <= w_vuop;
         r_new_seg <= w_new_seg;
      end
   end

   // Next-state: micro-op index advances first, then the field, then completion.
   always_comb begin
      w_state   = r_state;
      w_store   = r_store;
      w_mode    = r_mode;
      w_base    = r_base;
      w_stride  = r_stride;
      w_eew     = r_eew;
      w_nuops   = r_nuops;
      w_nf      = r_nf;
      w_f       = r_f;
      w_vuop    = r_vuop;
      w_new_seg = r_new_seg;

      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) begin
               w_store   = bus.req_store;
               w_mode    = bus.req_mode;
               w_base    = bus.req_base;
               w_stride  = bus.req_stride;
               w_eew     = bus.req_eew;
               w_nuops   = bus.req_nuops;
               w_nf      = bus.req_nf;
               w_f       = '0;
               w_vuop    = '0;
               if (bus.req_nuops == '0) begin
                  w_state   = S_DONE;
                  w_new_seg = 1'b0;
               end else begin
                  w_state   = S_RUN;
                  w_new_seg = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (w_cmpl) begin
               if (!w_uop_last) begin
                  w_vuop    = r_vuop + UOP_W'(1);
                  w_new_seg = 1'b0;
               end else if (r_f < r_nf) begin
                  w_vuop    = '0;
                  w_f       = r_f + NF_W'(1);
                  w_new_seg = 1'b1;
               end else begin
                  w_state   = S_DONE;
                  w_new_seg = 1'b0;
               end
            end else if (!w_stall) begin
               // A stalled final lane freezes every output, including the new-field marker.
               w_new_seg = 1'b0;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state only; all per-op qualifiers read as zero outside RUN.
   assign w_run         = (r_state == S_RUN);
   assign w_unit        = (r_mode == 2'd0) || (r_mode == 2'd3);
   assign w_strd_mode   = (r_mode == 2'd1);
   assign w_idx_mode    = (r_mode == 2'd2);
   assign w_unit_stride = (32'({1'b0, r_nf}) + 32'd1) << r_eew;

   assign bus.req_ready    = (r_state == S_IDLE);
   assign bus.busy         = (r_state != S_IDLE);
   assign bus.done         = (r_state == S_DONE);
   assign bus.vmemdren     = w_run && !r_store;
   assign bus.vmemdwen     = w_run && r_store;
   assign bus.vuop_num     = w_run ? r_vuop : '0;
   assign bus.vuop_last    = w_run && w_uop_last;
   assign bus.vnew_seg     = w_run && r_new_seg;
   assign bus.vseg_op      = w_run && (r_nf != '0);
   assign bus.unit_strided = w_run && w_unit && (r_nf == '0);
   assign bus.strided      = w_run && (w_strd_mode || (w_unit && (r_nf != '0)));
   assign bus.vindexed     = w_run && w_idx_mode;
   assign bus.veew         = r_eew;
   assign bus.base         = w_run ? (r_base + (32'(r_f) << r_eew)) : 32'd0;
   assign bus.stride       = !w_run      ? 32'd0 :
                             w_strd_mode ? r_stride :
                             w_idx_mode  ? 32'd0 : w_unit_stride;

endmodule
